fetch_unit: RTL and testbench

- Instruction-fetch front end that owns the program counter and issues word reads to the instruction memory over a request/grant/response handshake.
- Tolerates variable memory latency.
- Buffers returned words in a small in-order prefetch FIFO.
- Presents {instruction, PC+4} to the IF/ID pipeline register with a valid/ready handshake.
- Handles branch redirects from the ID-stage branch unit and stops fetching at the program-end word.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the prefetch entry layout used by the fetch front end.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO of {instruction, PC+4} entries with synchronous flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];

    logic push_en;
    logic pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_en) wr_d = wr_q + PW'(1);
            if (pop_en)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush_i) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request credits, stale-response dropping,
// halt detection and the IF/ID handshake around the prefetch FIFO.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUT   = 2,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    output logic        halted
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned OW = $clog2(MAX_OUT+1);
    localparam int unsigned SW = $clog2(DEPTH+MAX_OUT+1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic          stop_q, stop_d;
    logic          halted_q, halted_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [SW-1:0] credit;
    logic          accept;
    logic          drop_rsp;

    // Words already queued plus requests that will still land here.
    assign credit = SW'(fifo_count) + SW'(out_q) - SW'(drop_q);

    assign imem_req  = rst_n && !stop_q && !redirect
                       && (credit < SW'(DEPTH)) && (out_q < OW'(MAX_OUT));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_gnt;

    assign drop_rsp   = imem_rvalid && (drop_q != '0);
    assign fifo_push  = imem_rvalid && (drop_q == '0) && !redirect;
    assign push_entry = '{instr: imem_rdata, pc4: next_pc(resp_pc_q)};

    assign if_valid = !fifo_empty;
    assign if_instr = fifo_head.instr;
    assign if_pc4   = fifo_head.pc4;
    assign fifo_pop = if_valid && id_ready && !redirect;
    assign halted   = halted_q;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q + OW'(accept) - OW'(imem_rvalid);
        drop_d    = drop_q;
        stop_d    = stop_q;
        halted_d  = halted_q;

        if (accept)   pc_d   = next_pc(pc_q);
        if (drop_rsp) drop_d = drop_q - OW'(1);

        if (fifo_push) begin
            resp_pc_d = next_pc(resp_pc_q);
            if (imem_rdata == HALT_WORD) begin
                stop_d = 1'b1;
                drop_d = out_d;
            end
        end

        if (fifo_pop && (fifo_head.instr == HALT_WORD)) halted_d = 1'b1;

        // Everything still in flight after a redirect belongs to the old path.
        if (redirect) begin
            pc_d      = align_pc(redirect_pc);
            resp_pc_d = align_pc(redirect_pc);
            stop_d    = 1'b0;
            halted_d  = 1'b0;
            drop_d    = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            stop_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            stop_q    <= stop_d;
            halted_q  <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (redirect),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(fifo_push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order variable-latency memory model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        id_ready;
    logic        halted;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH     (DEPTH),
        .MAX_OUT   (MAX_OUT),
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc4      (if_pc4),
        .id_ready    (id_ready),
        .halted      (halted)
    );

    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned last_due = 0;
    int unsigned pops    = 0;

    int unsigned gnt_pct, rdy_pct, lat_min, lat_max;
    logic        do_redirect;
    logic [31:0] redir_pc;

    logic [31:0] model_pc;
    logic        halt_seen, model_halted, halt_en;
    logic [31:0] halt_addr;
    logic        last_req, last_pop;
    logic [31:0] last_pop_pc4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (halt_en && a == halt_addr) ? HALT : a;
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit later, update models.
    task automatic step();
        logic        accept, pop, resp, nxt_halted;
        int unsigned due;
        mreq_t       m;
        exp_t        e;
        @(negedge clk);
        cyc++;
        check_eq("halted", {31'b0, halted}, {31'b0, model_halted});
        id_ready    = ($urandom_range(99) < rdy_pct);
        redirect    = do_redirect;
        redirect_pc = redir_pc;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        resp        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? word_at(mem_q[0].addr) : $urandom();
        #1;
        accept     = imem_req && imem_gnt;
        pop        = if_valid && id_ready && !redirect;
        last_req   = imem_req;
        last_pop   = pop;
        nxt_halted = model_halted;
        if (redirect) check_eq("req_in_redirect", {31'b0, imem_req}, 32'd0);
        if (accept) begin
            check_eq("imem_addr", imem_addr, model_pc);
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{model_pc, due});
            check_eq("outstanding_le_max", {31'b0, mem_q.size() <= MAX_OUT}, 32'd1);
            if (!halt_seen) begin
                exp_q.push_back('{word_at(model_pc), model_pc + 32'd4});
                if (word_at(model_pc) == HALT) halt_seen = 1'b1;
            end
            model_pc = model_pc + 32'd4;
        end
        if (resp) m = mem_q.pop_front();
        if (pop) begin
            pops++;
            last_pop_pc4 = if_pc4;
            if (exp_q.size() == 0) begin
                check_eq("spurious_if_valid", {31'b0, if_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("if_instr", if_instr, e.instr);
                check_eq("if_pc4", if_pc4, e.pc4);
                if (e.instr == HALT) nxt_halted = 1'b1;
            end
        end
        if (redirect) begin
            exp_q.delete();
            halt_seen  = 1'b0;
            model_pc   = {redir_pc[31:2], 2'b00};
            nxt_halted = 1'b0;
        end
        model_halted = nxt_halted;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        do_redirect = 1'b0;
        id_ready    = 1'b0;
        mem_q.delete();
        exp_q.delete();
        model_pc     = 32'h0;
        halt_seen    = 1'b0;
        model_halted = 1'b0;
        last_due     = cyc;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        do_redirect = 1'b0;
        redir_pc    = '0;
        model_pc    = '0;
        halt_seen   = 1'b0;
        model_halted = 1'b0;
        halt_en     = 1'b0;
        halt_addr   = 32'h10;
        last_req    = 1'b0;
        last_pop    = 1'b0;
        last_pop_pc4 = '0;

        #3;
        check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_if_instr", if_instr, 32'd0);
        check_eq("rst_if_pc4", if_pc4, 32'd0);
        check_eq("rst_halted", {31'b0, halted}, 32'd0);
        #24 rst_n = 1'b1;

        // Streaming, 1-cycle latency
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        repeat (5) step();
        pops = 0;
        repeat (20) step();
        check_eq("stream_rate", pops, 32'd20);

        // Backpressure from reset
        apply_reset();
        rdy_pct = 0;
        repeat (10) step();
        check_eq("bp_req_low", {31'b0, last_req}, 32'd0);
        check_eq("bp_held_words", exp_q.size(), 32'd4);
        check_eq("bp_if_valid", {31'b0, if_valid}, 32'd1);
        check_eq("bp_head_pc4", if_pc4, 32'h4);
        check_eq("bp_head_instr", if_instr, 32'h0);
        rdy_pct = 100;
        repeat (10) step();

        // Random grant and latency, random stalls
        gnt_pct = 50; rdy_pct = 70; lat_min = 1; lat_max = 3;
        repeat (200) step();

        // Redirect with two requests in flight, one responding in the same cycle
        gnt_pct = 100; rdy_pct = 100; lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_q.size() == 2 && mem_q[0].due == cyc + 1) found = 1'b1;
            else step();
        end
        check_eq("redir_setup_found", {31'b0, found}, 32'd1);
        do_redirect = 1'b1;
        redir_pc    = 32'h0000_0102;
        step();
        do_redirect = 1'b0;
        last_pop = 1'b0;
        for (int i = 0; i < 20 && !last_pop; i++) step();
        check_eq("redir_word_seen", {31'b0, last_pop}, 32'd1);
        check_eq("redir_first_pc4", last_pop_pc4, 32'h104);
        repeat (10) step();

        // Halt at 0x10, then resume via redirect
        apply_reset();
        halt_en = 1'b1; halt_addr = 32'h10;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40 && !model_halted; i++) step();
        check_eq("halt_word_popped", {31'b0, model_halted}, 32'd1);
        check_eq("halt_pc4", last_pop_pc4, 32'h14);
        repeat (5) begin
            step();
            check_eq("halt_no_req", {31'b0, last_req}, 32'd0);
            check_eq("halt_no_valid", {31'b0, if_valid}, 32'd0);
        end
        halt_en = 1'b0;
        do_redirect = 1'b1;
        redir_pc    = 32'h0;
        step();
        do_redirect = 1'b0;
        pops = 0;
        repeat (10) step();
        check_eq("resume_after_halt", {31'b0, pops > 0}, 32'd1);
        check_eq("halted_cleared", {31'b0, halted}, 32'd0);

        // Asynchronous reset between edges mid-stream
        repeat (10) step();
        @(negedge clk);
        #3;
        check_eq("pre_reset_valid", {31'b0, if_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_if_valid", {31'b0, if_valid}, 32'd0);
        check_eq("async_rst_imem_req", {31'b0, imem_req}, 32'd0);
        apply_reset();
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
